seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Scan scheduler for the 4-digit 7-segment display path. Drives the 2-bit digit select of the
//  registered digit/anode mux, time-slices the display among enabled digits, inserts an
//  anti-ghosting blank at every digit change and applies 16-level PWM brightness per slot.
//  Sits between the system clock domain and the display mux; emits frame ticks for value updates.
// PARAMETERS
//  SLOT_CYC   50000  clk cycles per digit slot (>= BLANK_CYC+16)
//  BLANK_CYC  500    cycles at slot start with all anodes forced off
//  CNT_W      16     width of the slot counter (2**CNT_W > SLOT_CYC)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  synchronous reset, active low
//  en          in   1  1 = scanning enabled; 0 = display dark
//  dig_en      in   4  bit i = digit i participates in scan
//  bright      in   4  PWM level 0 (dark) .. 15 (full on-period)
//  sel         out  2  digit index to display mux
//  blank       out  1  1 = all anodes must be off (mux output gated downstream)
//  slot_tick   out  1  1-cycle pulse on first cycle of every slot
//  frame_tick  out  1  1-cycle pulse on first cycle of a new scan frame
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, sel=0, blank=1, slot_tick=0, frame_tick=0, cnt=0.
//  States: IDLE, BLANK, ON, OFF. All outputs registered.
//  Local: ON_MAX = SLOT_CYC-BLANK_CYC; STEP = ON_MAX/16 (integer); on_len = bright_l==15 ?
//    ON_MAX : bright_l*STEP. bright_l, dig_en_l = copies latched at each slot start only.
//  IDLE: blank=1. If en=1 and dig_en!=0: next cycle -> BLANK, sel=lowest set bit of dig_en,
//    cnt=0, slot_tick=1, frame_tick=1, latch bright/dig_en.
//  BLANK: blank=1 while cnt<BLANK_CYC; at cnt=BLANK_CYC-1 -> ON (or OFF if on_len=0).
//  ON: blank=0 while cnt-BLANK_CYC < on_len; then -> OFF (if on_len=ON_MAX, stay ON to slot end).
//  OFF: blank=1 until slot end.
//  Slot end (cnt=SLOT_CYC-1): cnt->0, next sel = next set bit of current dig_en above sel,
//    cyclically wrapping; state -> BLANK; slot_tick=1; frame_tick=1 iff new sel <= old sel
//    (wrap, incl. single enabled digit -> every slot). New dig_en/bright take effect here.
//  dig_en becomes 0 at a slot end -> IDLE, blank=1, sel held. Mid-slot dig_en changes ignored.
//  en=0 at any cycle -> next cycle IDLE, blank=1, cnt=0, sel held; no ticks.
//  rst_n=0 mid-slot overrides everything (reset values next cycle).
//  sel only changes on a cycle where blank=1 is also registered -> glitch-free anode switching;
//    downstream mux adds 1 cycle, so BLANK_CYC>=2 is required.
//  cnt never exceeds SLOT_CYC-1; no overflow path.
// TESTING (SLOT_CYC=40, BLANK_CYC=4 for sim; STEP=2)
//  Reset 3 cycles, en=1, dig_en=1111, bright=15 -> sel 0,1,2,3,0 each 40 cyc; blank=1 first 4
//    cyc of slot, 0 for 36; frame_tick every 160 cyc, slot_tick every 40.
//  dig_en=0101, bright=15 -> sel alternates 0,2; frame_tick every 80 cyc with sel=0.
//  bright=5 -> per slot blank=1 for 4, 0 for 10, 1 for 26; bright=0 -> blank=1 whole slot.
//  Change dig_en 1111->0010 mid-slot of sel=1 -> current slot completes; next sel=1, frame_tick=1.
//  en dropped mid ON -> blank=1 next cycle, sel held, no ticks; en=1 -> restart at lowest digit.
//  rst_n=0 during ON at sel=2 -> next cycle sel=0, blank=1, ticks 0; dig_en=0 -> stays IDLE.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit 7-segment scan scheduler with anti-ghost blanking and PWM
// Time-slices enabled digits; sel only moves on cycles where blank is also asserted.
module seg_scan_ctrl #(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] dig_en,
  input  logic [3:0] bright,
  output logic [1:0] sel,
  output logic       blank,
  output logic       slot_tick,
  output logic       frame_tick
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;
  localparam logic [1:0] S_OFF   = 2'd3;

  localparam logic [CNT_W-1:0] SLOT_END   = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LEN  = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] ON_MAX     = CNT_W'(SLOT_CYC - BLANK_CYC);
  localparam logic [CNT_W-1:0] STEP       = CNT_W'((SLOT_CYC - BLANK_CYC) / 16);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             blank_q, blank_d;
  logic             slot_tick_q, slot_tick_d;
  logic             frame_tick_q, frame_tick_d;
  logic [3:0]       bright_q, bright_d;

  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] on_end;
  logic [CNT_W-1:0] cnt_inc;
  logic             end_slot;
  logic [1:0]       nxt_sel;

  function automatic logic [1:0] lowest_sel(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Search upward from the current digit, wrapping; a lone enabled digit finds itself.
  function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = cur + 2'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign on_len  = (bright_q == 4'd15) ? ON_MAX : CNT_W'(bright_q) * STEP;
  assign on_end  = BLANK_LEN + on_len;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign nxt_sel = next_sel(sel_q, dig_en);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    bright_d     = bright_q;
    slot_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    end_slot     = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dig_en != 4'd0) begin
            state_d      = S_BLANK;
            cnt_d        = '0;
            sel_d        = lowest_sel(dig_en);
            bright_d     = bright;
            slot_tick_d  = 1'b1;
            frame_tick_d = 1'b1;
          end
        end
        S_BLANK: begin
          cnt_d = cnt_inc;
          if (cnt_q == BLANK_LAST) state_d = (on_len == '0) ? S_OFF : S_ON;
        end
        S_ON: begin
          if (cnt_q == SLOT_END) begin
            end_slot = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == on_end) state_d = S_OFF;
          end
        end
        default: begin
          if (cnt_q == SLOT_END) end_slot = 1'b1;
          else                   cnt_d    = cnt_inc;
        end
      endcase

      if (end_slot) begin
        cnt_d = '0;
        if (dig_en == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d      = S_BLANK;
          sel_d        = nxt_sel;
          bright_d     = bright;
          slot_tick_d  = 1'b1;
          frame_tick_d = (nxt_sel <= sel_q);
        end
      end
    end

    blank_d = (state_d != S_ON);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sel_q        <= 2'd0;
      blank_q      <= 1'b1;
      slot_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      bright_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      blank_q      <= blank_d;
      slot_tick_q  <= slot_tick_d;
      frame_tick_q <= frame_tick_d;
      bright_q     <= bright_d;
    end
  end

  assign sel        = sel_q;
  assign blank      = blank_q;
  assign slot_tick  = slot_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
// Stimulus queues one record per expected slot; the monitor checks each slot as it runs.
module tb_seg_scan_ctrl;

  localparam int SLOT = 40;
  localparam int BLK  = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] dig_en;
  logic [3:0] bright;
  logic [1:0] sel;
  logic       blank;
  logic       slot_tick;
  logic       frame_tick;

  int total;
  int bad;

  typedef struct {
    logic [1:0] sel;
    logic       frame;
    int         on_len;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   active;
  int   k;
  int   berr;
  logic exp_b;

  seg_scan_ctrl #(.SLOT_CYC(SLOT), .BLANK_CYC(BLK), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .dig_en     (dig_en),
    .bright     (bright),
    .sel        (sel),
    .blank      (blank),
    .slot_tick  (slot_tick),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [1:0] s, input logic f, input int on_len, input int len);
    exp_t e;
    e.sel    = s;
    e.frame  = f;
    e.on_len = on_len;
    e.len    = len;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (slot_tick === 1'b1) begin
      if (active) begin
        total++;
        bad++;
        $display("FAIL slot_short: new slot after %0d cycles, required %0d", k + 1, cur.len);
        active = 1'b0;
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tick: sel=%0d, required no slot start", sel);
      end else begin
        cur    = exp_q.pop_front();
        active = 1'b1;
        k      = 0;
        berr   = 0;
        if (sel !== cur.sel || frame_tick !== cur.frame) begin
          bad++;
          $display("FAIL slot_start: sel=%0d frame=%0b, required sel=%0d frame=%0b",
                   sel, frame_tick, cur.sel, cur.frame);
        end
      end
    end else if (active) begin
      k++;
    end

    if (frame_tick === 1'b1 && slot_tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL frame_alone: frame_tick=1 slot_tick=%0b, required slot_tick=1", slot_tick);
    end

    if (active) begin
      exp_b = !(k >= BLK && k < BLK + cur.on_len);
      if (blank !== exp_b || sel !== cur.sel) berr++;
      if (k == cur.len - 1) begin
        total++;
        if (berr != 0) begin
          bad++;
          $display("FAIL slot_body sel=%0d: %0d bad cycles, required 0", cur.sel, berr);
        end
        active = 1'b0;
      end
    end
  end

  initial begin
    total  = 0;
    bad    = 0;
    active = 1'b0;
    k      = 0;
    berr   = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    dig_en = 4'b0000;
    bright = 4'd0;
    cyc(3);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_slot_tick", 32'(slot_tick), 32'd0);
    chk("rst_frame_tick", 32'(frame_tick), 32'd0);

    // All digits at full brightness, then 0101 alternation
    rst_n  = 1'b1;
    en     = 1'b1;
    dig_en = 4'b1111;
    bright = 4'd15;
    push(2'd0, 1'b1, 36, SLOT);
    push(2'd1, 1'b0, 36, SLOT);
    push(2'd2, 1'b0, 36, SLOT);
    push(2'd3, 1'b0, 36, SLOT);
    push(2'd0, 1'b1, 36, SLOT);
    cyc(1);
    cyc(4 * SLOT + 20);
    dig_en = 4'b0101;
    push(2'd2, 1'b0, 36, SLOT);
    push(2'd0, 1'b1, 36, SLOT);
    push(2'd2, 1'b0, 36, SLOT);
    cyc(3 * SLOT);
    bright = 4'd5;
    push(2'd0, 1'b1, 10, SLOT);
    cyc(SLOT);
    bright = 4'd0;
    push(2'd2, 1'b0, 0, SLOT);
    cyc(SLOT);
    bright = 4'd15;
    dig_en = 4'b1111;
    push(2'd3, 1'b0, 36, SLOT);
    push(2'd0, 1'b1, 36, SLOT);
    push(2'd1, 1'b0, 36, SLOT);
    cyc(3 * SLOT);
    dig_en = 4'b0010;
    push(2'd1, 1'b1, 36, SLOT);
    push(2'd1, 1'b1, 36, 21);
    cyc(2 * SLOT);

    // Drop enable in the ON phase of sel=1
    en = 1'b0;
    cyc(1);
    chk("en_off_blank", 32'(blank), 32'd1);
    chk("en_off_sel", 32'(sel), 32'd1);
    chk("en_off_slot_tick", 32'(slot_tick), 32'd0);
    cyc(10);
    chk("en_off_hold_blank", 32'(blank), 32'd1);
    chk("en_off_hold_sel", 32'(sel), 32'd1);

    // Restart at lowest enabled digit, then reset during ON at sel=2
    dig_en = 4'b1100;
    en     = 1'b1;
    push(2'd2, 1'b1, 36, SLOT);
    push(2'd3, 1'b0, 36, SLOT);
    push(2'd2, 1'b1, 36, 11);
    cyc(1);
    cyc(2 * SLOT + 10);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_blank", 32'(blank), 32'd1);
    chk("mid_rst_ticks", {30'd0, slot_tick, frame_tick}, 32'd0);
    rst_n  = 1'b1;
    dig_en = 4'b0000;
    cyc(10);
    chk("idle_no_dig_blank", 32'(blank), 32'd1);
    chk("idle_no_dig_sel", 32'(sel), 32'd0);

    // Single digit, then dig_en cleared so the slot end falls back to IDLE
    dig_en = 4'b1000;
    push(2'd3, 1'b1, 36, SLOT);
    cyc(1);
    cyc(20);
    dig_en = 4'b0000;
    cyc(20);
    chk("dig_off_blank", 32'(blank), 32'd1);
    chk("dig_off_sel", 32'(sel), 32'd3);
    chk("dig_off_slot_tick", 32'(slot_tick), 32'd0);
    cyc(5);
    chk("dig_off_hold_blank", 32'(blank), 32'd1);
    chk("pending_slots", 32'(exp_q.size()), 32'd0);
    chk("slot_open", 32'(active), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
